// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back / register file slice.
package wb_regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned XLEN     = 32;

  localparam logic [31:0] NOP_INST      = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_4  = 32'h0000_0004;
  localparam logic [4:0]  LINK_REG_ADDR = 5'd31;

  // Effective write request as seen by the array and the bypass muxes.
  typedef struct packed {
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wr_req_t;

  // Read-port selection: $0 reads zero, a matching write is forwarded,
  // otherwise the stored value is returned.
  function automatic logic [XLEN-1:0] rd_sel(input logic [4:0]      addr,
                                             input wr_req_t         wr,
                                             input logic [XLEN-1:0] arr_val);
    if (addr == 5'd0)                    return '0;
    else if (wr.we && (wr.addr == addr)) return wr.data;
    else                                 return arr_val;
  endfunction

endpackage

// File: rtl/wb_commit.sv
// Resolves the effective write from the WB bundle and keeps the retire/load
// counters and the registered commit trace.
module wb_commit
  import wb_regfile_pkg::*;
#(
  parameter logic [4:0]  LINK_REG = LINK_REG_ADDR,
  parameter logic [31:0] NOP      = NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WB_memtoreg,
  input  logic        WB_regwrite,
  input  logic        WB_link,
  input  logic [31:0] WB_data,
  input  logic [4:0]  WB_wraddr,
  input  logic [31:0] WB_pc_4,
  input  logic [31:0] WB_inst,
  output wr_req_t     wr,
  output logic [31:0] retire_cnt,
  output logic [31:0] load_cnt,
  output logic        trace_valid,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data,
  output logic [31:0] trace_pc_4
);

  logic is_inst;

  // Link writes override both the destination and the data; $0 never commits.
  always_comb begin
    wr.addr = WB_link ? LINK_REG : WB_wraddr;
    wr.data = WB_link ? WB_pc_4  : WB_data;
    wr.we   = (WB_regwrite | WB_link) & (wr.addr != 5'd0);
  end

  assign is_inst = (WB_inst != NOP);

  // Free-running modulo-2^32 counters of retired instructions and loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      load_cnt   <= '0;
    end else begin
      if (is_inst)               retire_cnt <= retire_cnt + 32'd1;
      if (is_inst && WB_memtoreg) load_cnt  <= load_cnt + 32'd1;
    end
  end

  // Commit trace: valid follows every cycle, payload holds the last real commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
      trace_pc_4  <= '0;
    end else begin
      trace_valid <= wr.we;
      if (wr.we) begin
        trace_addr <= wr.addr;
        trace_data <= wr.data;
        trace_pc_4 <= WB_pc_4;
      end
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 GPRs with $0 hardwired to zero,
// two combinational read ports with write-through bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter logic [4:0]  LINK_REG = LINK_REG_ADDR,
  parameter logic [31:0] NOP      = NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WB_memtoreg,
  input  logic        WB_regwrite,
  input  logic        WB_link,
  input  logic [31:0] WB_data,
  input  logic [4:0]  WB_wraddr,
  input  logic [31:0] WB_pc_4,
  input  logic [31:0] WB_inst,
  input  logic [4:0]  ID_rs_addr,
  input  logic [4:0]  ID_rt_addr,
  output logic [31:0] ID_rs_data,
  output logic [31:0] ID_rt_data,
  output logic [31:0] retire_cnt,
  output logic [31:0] load_cnt,
  output logic        trace_valid,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data,
  output logic [31:0] trace_pc_4
);

  wr_req_t     wr;
  wr_req_t     byp;
  logic [31:0] regs [NUM_REGS];

  wb_commit #(
    .LINK_REG (LINK_REG),
    .NOP      (NOP)
  ) u_commit (
    .clk         (clk),
    .rst_n       (rst_n),
    .WB_memtoreg (WB_memtoreg),
    .WB_regwrite (WB_regwrite),
    .WB_link     (WB_link),
    .WB_data     (WB_data),
    .WB_wraddr   (WB_wraddr),
    .WB_pc_4     (WB_pc_4),
    .WB_inst     (WB_inst),
    .wr          (wr),
    .retire_cnt  (retire_cnt),
    .load_cnt    (load_cnt),
    .trace_valid (trace_valid),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .trace_pc_4  (trace_pc_4)
  );

  // Per-register flops; entry 0 is never written since wr.we excludes $0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr.we) begin
      regs[wr.addr] <= wr.data;
    end
  end

  // The bypass is suppressed while reset is held so reads show zero then.
  always_comb begin
    byp    = wr;
    byp.we = wr.we & rst_n;
  end

  assign ID_rs_data = rd_sel(ID_rs_addr, byp, regs[ID_rs_addr]);
  assign ID_rt_data = rd_sel(ID_rt_addr, byp, regs[ID_rt_addr]);

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, bypass, $0, link, counters, async reset.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        WB_memtoreg, WB_regwrite, WB_link;
  logic [31:0] WB_data, WB_pc_4, WB_inst;
  logic [4:0]  WB_wraddr, ID_rs_addr, ID_rt_addr;
  logic [31:0] ID_rs_data, ID_rt_data, retire_cnt, load_cnt;
  logic        trace_valid;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data, trace_pc_4;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] NOPI = 32'h0000_0000;
  localparam logic [31:0] ALU  = 32'h0123_4020;
  localparam logic [31:0] LW   = 32'h8C22_0004;

  wb_regfile dut (
    .clk (clk), .rst_n (rst_n),
    .WB_memtoreg (WB_memtoreg), .WB_regwrite (WB_regwrite), .WB_link (WB_link),
    .WB_data (WB_data), .WB_wraddr (WB_wraddr), .WB_pc_4 (WB_pc_4), .WB_inst (WB_inst),
    .ID_rs_addr (ID_rs_addr), .ID_rt_addr (ID_rt_addr),
    .ID_rs_data (ID_rs_data), .ID_rt_data (ID_rt_data),
    .retire_cnt (retire_cnt), .load_cnt (load_cnt),
    .trace_valid (trace_valid), .trace_addr (trace_addr),
    .trace_data (trace_data), .trace_pc_4 (trace_pc_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WB_memtoreg = 0; WB_regwrite = 0; WB_link = 0;
    WB_data = '0; WB_wraddr = '0; WB_pc_4 = 32'h0000_0004; WB_inst = NOPI;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic ld);
    WB_regwrite = 1; WB_link = 0; WB_wraddr = a; WB_data = d;
    WB_memtoreg = ld; WB_inst = ld ? LW : ALU;
  endtask

  initial begin
    idle();
    rst_n = 0;
    ID_rs_addr = 5'd5; ID_rt_addr = 5'd0;
    #3;
    chk("rst_rs", ID_rs_data, 32'h0);
    chk("rst_retire", retire_cnt, 32'h0);
    chk("rst_load", load_cnt, 32'h0);
    chk("rst_tvalid", {31'h0, trace_valid}, 32'h0);
    #9 rst_n = 1;   // released mid-cycle
    @(negedge clk);

    // write $5, read back from the array next cycle
    wr(5'd5, 32'h1234_5678, 1'b0);
    tick(); idle();
    chk("w5_rs", ID_rs_data, 32'h1234_5678);
    chk("w5_retire", retire_cnt, 32'd1);
    chk("w5_tvalid", {31'h0, trace_valid}, 32'h1);
    chk("w5_taddr", {27'h0, trace_addr}, 32'd5);
    chk("w5_tdata", trace_data, 32'h1234_5678);

    // both ports hit the write address: bypass, then array
    wr(5'd9, 32'hDEAD_BEEF, 1'b0);
    ID_rs_addr = 5'd9; ID_rt_addr = 5'd9;
    #1;
    chk("byp_rs_pre", ID_rs_data, 32'hDEAD_BEEF);
    chk("byp_rt_pre", ID_rt_data, 32'hDEAD_BEEF);
    tick(); idle();
    chk("byp_rs_post", ID_rs_data, 32'hDEAD_BEEF);
    chk("byp_rt_post", ID_rt_data, 32'hDEAD_BEEF);

    // write to $0 is discarded
    wr(5'd0, 32'hFFFF_FFFF, 1'b0);
    ID_rs_addr = 5'd0;
    #1;
    chk("r0_pre", ID_rs_data, 32'h0);
    tick(); idle();
    chk("r0_post", ID_rs_data, 32'h0);
    chk("r0_tvalid", {31'h0, trace_valid}, 32'h0);
    chk("r0_retire", retire_cnt, 32'd3);

    // link write overrides regwrite/wraddr/data
    wr(5'd3, 32'h3333_3333, 1'b0);
    tick();
    WB_regwrite = 0; WB_link = 1; WB_wraddr = 5'd3; WB_data = 32'hAAAA_AAAA;
    WB_pc_4 = 32'h0040_0010; WB_inst = ALU;
    ID_rs_addr = 5'd31; ID_rt_addr = 5'd3;
    #1;
    chk("lnk_byp31", ID_rs_data, 32'h0040_0010);
    chk("lnk_byp3", ID_rt_data, 32'h3333_3333);
    tick(); idle();
    chk("lnk_r31", ID_rs_data, 32'h0040_0010);
    chk("lnk_r3", ID_rt_data, 32'h3333_3333);
    chk("lnk_taddr", {27'h0, trace_addr}, 32'd31);
    chk("lnk_tdata", trace_data, 32'h0040_0010);
    chk("lnk_tpc", trace_pc_4, 32'h0040_0010);

    // counters from a clean reset: 3 ALU, 2 loads, 4 NOPs
    #2 rst_n = 0;
    #2 rst_n = 1;
    @(negedge clk);
    wr(5'd1, 32'h1, 1'b0); tick();
    wr(5'd2, 32'h2, 1'b1); tick();
    wr(5'd4, 32'h4, 1'b0); tick();
    wr(5'd6, 32'h6, 1'b1); tick();
    wr(5'd8, 32'h8, 1'b0); tick();
    idle(); WB_memtoreg = 1; tick();   // NOP with memtoreg set still counts nothing
    idle(); tick(); tick(); tick();
    chk("cnt_retire", retire_cnt, 32'd5);
    chk("cnt_load", load_cnt, 32'd2);

    // wrap of retire_cnt
    force dut.u_commit.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.u_commit.retire_cnt;
    #1;
    chk("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
    wr(5'd10, 32'hA, 1'b0);
    tick(); idle();
    chk("wrap_retire", retire_cnt, 32'h0);
    chk("wrap_load", load_cnt, 32'd2);

    // async reset in the middle of a $7 write
    wr(5'd7, 32'h7777_7777, 1'b0); tick();
    wr(5'd7, 32'h5555_5555, 1'b0);
    ID_rs_addr = 5'd7; ID_rt_addr = 5'd5;
    #2 rst_n = 0;
    #1;
    chk("ar_r7", ID_rs_data, 32'h0);
    chk("ar_retire", retire_cnt, 32'h0);
    chk("ar_load", load_cnt, 32'h0);
    chk("ar_tvalid", {31'h0, trace_valid}, 32'h0);
    chk("ar_taddr", {27'h0, trace_addr}, 32'h0);
    chk("ar_tdata", trace_data, 32'h0);
    chk("ar_tpc", trace_pc_4, 32'h0);
    idle();
    #1 rst_n = 1;
    tick();
    chk("ar_r7_after", ID_rs_data, 32'h0);
    chk("ar_retire_after", retire_cnt, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
